// File: rtl/apb2axi_issue_sched.sv
// APB-to-AXI issue scheduler: pops PENDING directory entries in order, issues them
// to the AR or AW/W builder under per-direction credit limits, and arbitrates
// read/write completions back to the directory.
// Optional statistics counters are built when APB2AXI_SCHED_STATS_EN is defined.

package apb2axi_issue_sched_pkg;
  localparam int unsigned TAG_NUM = 16;
  localparam int unsigned TAG_W   = 4;

  typedef struct packed {
    logic        is_write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } directory_entry_t;
endpackage

module apb2axi_issue_sched
  import apb2axi_issue_sched_pkg::*;
#(
  parameter int unsigned TAG_NUM_P    = TAG_NUM,
  parameter int unsigned TAG_W_P      = TAG_W,
  parameter int unsigned MAX_OUTST_RD = 4,
  parameter int unsigned MAX_OUTST_WR = 4,
  localparam int unsigned RD_CW = $clog2(MAX_OUTST_RD + 1),
  localparam int unsigned WR_CW = $clog2(MAX_OUTST_WR + 1)
) (
  input  logic                   pclk,
  input  logic                   preset,
  input  logic                   sched_en,
  input  logic                   pending_valid,
  input  directory_entry_t       pending_entry,
  input  logic [TAG_W_P-1:0]     pending_tag,
  output logic                   pending_pop,
  output logic                   rd_issue_valid,
  input  logic                   rd_issue_ready,
  output logic                   wr_issue_valid,
  input  logic                   wr_issue_ready,
  output directory_entry_t       issue_entry,
  output logic [TAG_W_P-1:0]     issue_tag,
  input  logic                   rd_cpl_valid,
  input  logic [TAG_W_P-1:0]     rd_cpl_tag,
  input  logic                   rd_cpl_err,
  output logic                   rd_cpl_ready,
  input  logic                   wr_cpl_valid,
  input  logic [TAG_W_P-1:0]     wr_cpl_tag,
  input  logic                   wr_cpl_err,
  output logic                   wr_cpl_ready,
  output logic                   cpl_valid,
  output logic [TAG_W_P-1:0]     cpl_tag,
  output logic                   cpl_error,
  output logic [RD_CW-1:0]       rd_outst,
  output logic [WR_CW-1:0]       wr_outst,
`ifdef APB2AXI_SCHED_STATS_EN
  output logic [31:0]            stat_issued,
  output logic [31:0]            stat_cpl_ok,
  output logic [31:0]            stat_cpl_err,
  output logic [31:0]            stat_stall_cycles,
`endif
  output logic                   spurious_cpl
);

  localparam logic [RD_CW-1:0] RD_MAX = RD_CW'(MAX_OUTST_RD);
  localparam logic [WR_CW-1:0] WR_MAX = WR_CW'(MAX_OUTST_WR);

  typedef enum logic {ST_IDLE, ST_ISSUE} state_e;

  state_e                 state_q, state_d;
  directory_entry_t       entry_q, entry_d;
  logic [TAG_W_P-1:0]     tag_q, tag_d;
  logic [TAG_NUM_P-1:0]   inflight_q, inflight_d;
  logic [TAG_NUM_P-1:0]   dir_wr_q, dir_wr_d;
  logic [RD_CW-1:0]       rd_outst_q, rd_outst_d;
  logic [WR_CW-1:0]       wr_outst_q, wr_outst_d;
  logic                   rr_wr_q, rr_wr_d;
  logic                   cpl_valid_q, cpl_valid_d;
  logic [TAG_W_P-1:0]     cpl_tag_q, cpl_tag_d;
  logic                   cpl_err_q, cpl_err_d;
  logic                   spurious_q, spurious_d;

  logic                   head_credit;
  logic                   pop;
  logic                   rd_v, wr_v;
  logic                   grant_rd, grant_wr, cpl_any, cpl_legal;
  logic [TAG_W_P-1:0]     sel_tag;
  logic                   sel_err;

  // Credit check on the pre-update counts for the head entry's direction
  always_comb begin
    head_credit = pending_entry.is_write ? (wr_outst_q < WR_MAX) : (rd_outst_q < RD_MAX);
  end

  // Issue FSM next-state and handshake outputs
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    rd_v    = 1'b0;
    wr_v    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sched_en && pending_valid && head_credit) begin
          pop     = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        rd_v = !entry_q.is_write;
        wr_v = entry_q.is_write;
        if ((rd_v && rd_issue_ready) || (wr_v && wr_issue_ready)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Round-robin completion arbiter; rr_wr_q=1 gives write priority on a tie
  always_comb begin
    grant_wr  = wr_cpl_valid && (!rd_cpl_valid || rr_wr_q);
    grant_rd  = rd_cpl_valid && !grant_wr;
    cpl_any   = grant_rd || grant_wr;
    sel_tag   = grant_wr ? wr_cpl_tag : rd_cpl_tag;
    sel_err   = grant_wr ? wr_cpl_err : rd_cpl_err;
    cpl_legal = inflight_q[sel_tag] && (dir_wr_q[sel_tag] == grant_wr);
  end

  // Tag bookkeeping, counters and completion forwarding
  always_comb begin
    inflight_d  = inflight_q;
    dir_wr_d    = dir_wr_q;
    entry_d     = entry_q;
    tag_d       = tag_q;
    rr_wr_d     = rr_wr_q;
    spurious_d  = spurious_q;
    cpl_valid_d = 1'b0;
    cpl_tag_d   = cpl_tag_q;
    cpl_err_d   = cpl_err_q;
    if (cpl_any) begin
      rr_wr_d = grant_rd;
      if (cpl_legal) begin
        inflight_d[sel_tag] = 1'b0;
        cpl_valid_d         = 1'b1;
        cpl_tag_d           = sel_tag;
        cpl_err_d           = sel_err;
      end else begin
        spurious_d = 1'b1;
      end
    end
    // Set after clear so a same-cycle pop of a just-freed tag wins
    if (pop) begin
      entry_d                = pending_entry;
      tag_d                  = pending_tag;
      inflight_d[pending_tag] = 1'b1;
      dir_wr_d[pending_tag]   = pending_entry.is_write;
    end
    rd_outst_d = rd_outst_q + RD_CW'(pop && !pending_entry.is_write)
                            - RD_CW'(cpl_any && cpl_legal && grant_rd);
    wr_outst_d = wr_outst_q + WR_CW'(pop && pending_entry.is_write)
                            - WR_CW'(cpl_any && cpl_legal && grant_wr);
  end

  // State and bookkeeping registers
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q     <= ST_IDLE;
      entry_q     <= '0;
      tag_q       <= '0;
      inflight_q  <= '0;
      dir_wr_q    <= '0;
      rd_outst_q  <= '0;
      wr_outst_q  <= '0;
      rr_wr_q     <= 1'b1;
      cpl_valid_q <= 1'b0;
      cpl_tag_q   <= '0;
      cpl_err_q   <= 1'b0;
      spurious_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      entry_q     <= entry_d;
      tag_q       <= tag_d;
      inflight_q  <= inflight_d;
      dir_wr_q    <= dir_wr_d;
      rd_outst_q  <= rd_outst_d;
      wr_outst_q  <= wr_outst_d;
      rr_wr_q     <= rr_wr_d;
      cpl_valid_q <= cpl_valid_d;
      cpl_tag_q   <= cpl_tag_d;
      cpl_err_q   <= cpl_err_d;
      spurious_q  <= spurious_d;
    end
  end

  // Combinational strobes are masked while reset is held so every output reads 0
  assign pending_pop    = pop && !preset;
  assign rd_cpl_ready   = grant_rd && !preset;
  assign wr_cpl_ready   = grant_wr && !preset;
  assign rd_issue_valid = rd_v;
  assign wr_issue_valid = wr_v;
  assign issue_entry    = entry_q;
  assign issue_tag      = tag_q;
  assign cpl_valid      = cpl_valid_q;
  assign cpl_tag        = cpl_tag_q;
  assign cpl_error      = cpl_err_q;
  assign rd_outst       = rd_outst_q;
  assign wr_outst       = wr_outst_q;
  assign spurious_cpl   = spurious_q;

`ifdef APB2AXI_SCHED_STATS_EN
  logic [31:0] st_iss_q, st_ok_q, st_err_q, st_stall_q;

  // Saturating event counters
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      st_iss_q   <= '0;
      st_ok_q    <= '0;
      st_err_q   <= '0;
      st_stall_q <= '0;
    end else begin
      if (pop && st_iss_q != '1) st_iss_q <= st_iss_q + 32'd1;
      if (cpl_any && cpl_legal && !sel_err && st_ok_q != '1) st_ok_q <= st_ok_q + 32'd1;
      if (cpl_any && cpl_legal && sel_err && st_err_q != '1) st_err_q <= st_err_q + 32'd1;
      if (pending_valid && sched_en && !head_credit && st_stall_q != '1)
        st_stall_q <= st_stall_q + 32'd1;
    end
  end

  assign stat_issued       = st_iss_q;
  assign stat_cpl_ok       = st_ok_q;
  assign stat_cpl_err      = st_err_q;
  assign stat_stall_cycles = st_stall_q;
`endif

endmodule

// File: tb/tb_apb2axi_issue_sched.sv
// Self-checking bench for apb2axi_issue_sched: directed scenarios followed by
// randomized traffic, all compared against a tag-list reference model.
module tb_apb2axi_issue_sched;
  import apb2axi_issue_sched_pkg::*;

  localparam int unsigned MAXRD = 2;
  localparam int unsigned MAXWR = 4;
  localparam int unsigned RCW = $clog2(MAXRD + 1);
  localparam int unsigned WCW = $clog2(MAXWR + 1);

  logic pclk = 1'b0;
  logic preset;
  logic sched_en, pending_valid, pending_pop;
  directory_entry_t pending_entry, issue_entry;
  logic [TAG_W-1:0] pending_tag, issue_tag, rd_cpl_tag, wr_cpl_tag, cpl_tag;
  logic rd_issue_valid, rd_issue_ready, wr_issue_valid, wr_issue_ready;
  logic rd_cpl_valid, rd_cpl_err, rd_cpl_ready;
  logic wr_cpl_valid, wr_cpl_err, wr_cpl_ready;
  logic cpl_valid, cpl_error, spurious_cpl;
  logic [RCW-1:0] rd_outst;
  logic [WCW-1:0] wr_outst;
`ifdef APB2AXI_SCHED_STATS_EN
  logic [31:0] stat_issued, stat_cpl_ok, stat_cpl_err, stat_stall_cycles;
`endif

  apb2axi_issue_sched #(
    .TAG_NUM_P(TAG_NUM), .TAG_W_P(TAG_W),
    .MAX_OUTST_RD(MAXRD), .MAX_OUTST_WR(MAXWR)
  ) dut (
    .pclk(pclk), .preset(preset), .sched_en(sched_en),
    .pending_valid(pending_valid), .pending_entry(pending_entry),
    .pending_tag(pending_tag), .pending_pop(pending_pop),
    .rd_issue_valid(rd_issue_valid), .rd_issue_ready(rd_issue_ready),
    .wr_issue_valid(wr_issue_valid), .wr_issue_ready(wr_issue_ready),
    .issue_entry(issue_entry), .issue_tag(issue_tag),
    .rd_cpl_valid(rd_cpl_valid), .rd_cpl_tag(rd_cpl_tag), .rd_cpl_err(rd_cpl_err),
    .rd_cpl_ready(rd_cpl_ready),
    .wr_cpl_valid(wr_cpl_valid), .wr_cpl_tag(wr_cpl_tag), .wr_cpl_err(wr_cpl_err),
    .wr_cpl_ready(wr_cpl_ready),
    .cpl_valid(cpl_valid), .cpl_tag(cpl_tag), .cpl_error(cpl_error),
    .rd_outst(rd_outst), .wr_outst(wr_outst),
`ifdef APB2AXI_SCHED_STATS_EN
    .stat_issued(stat_issued), .stat_cpl_ok(stat_cpl_ok),
    .stat_cpl_err(stat_cpl_err), .stat_stall_cycles(stat_stall_cycles),
`endif
    .spurious_cpl(spurious_cpl)
  );

  always #5 pclk = ~pclk;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;

  // Reference model: a request slot, a set of in-flight tags with their direction,
  // whose turn it is on a completion tie, and the pending completion pulse.
  bit               m_busy, m_iswr;
  logic [TAG_W-1:0] m_tag;
  directory_entry_t m_entry;
  bit               m_infl[TAG_NUM];
  bit               m_dirw[TAG_NUM];
  bit               m_wr_turn;
  bit               m_cpl_v, m_cpl_e, m_spur;
  logic [TAG_W-1:0] m_cpl_t;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned cnt(input bit w);
    int unsigned n = 0;
    for (int i = 0; i < TAG_NUM; i++) if (m_infl[i] && m_dirw[i] == w) n++;
    return n;
  endfunction

  function automatic logic [TAG_W-1:0] pick_tag(input bit w);
    int unsigned off = $urandom_range(0, TAG_NUM - 1);
    logic [31:0] t;
    if ($urandom_range(0, 99) < 85)
      for (int i = 0; i < TAG_NUM; i++) begin
        t = (off + i) % TAG_NUM;
        if (m_infl[t] && m_dirw[t] == w) return t[TAG_W-1:0];
      end
    t = off;
    return t[TAG_W-1:0];
  endfunction

  task automatic model_reset();
    m_busy = 0; m_iswr = 0; m_tag = '0; m_entry = '0;
    for (int i = 0; i < TAG_NUM; i++) begin m_infl[i] = 0; m_dirw[i] = 0; end
    m_wr_turn = 1; m_cpl_v = 0; m_cpl_e = 0; m_cpl_t = '0; m_spur = 0;
  endtask

  task automatic clear_inputs();
    sched_en = 0; pending_valid = 0; pending_entry = '0; pending_tag = '0;
    rd_issue_ready = 0; wr_issue_ready = 0;
    rd_cpl_valid = 0; rd_cpl_tag = '0; rd_cpl_err = 0;
    wr_cpl_valid = 0; wr_cpl_tag = '0; wr_cpl_err = 0;
  endtask

  task automatic set_head(input bit v, input bit w, input int unsigned t);
    pending_valid          = v;
    pending_entry.is_write = w;
    pending_entry.addr     = $urandom;
    pending_entry.wdata    = $urandom;
    pending_entry.wstrb    = 4'($urandom);
    pending_tag            = t[TAG_W-1:0];
  endtask

  // Reset asserted asynchronously mid-cycle; all outputs must read 0 at once.
  task automatic do_reset();
    clear_inputs();
    preset = 1;
    #1;
    chk("rst_pending_pop", pending_pop, 0);
    chk("rst_rd_issue_valid", rd_issue_valid, 0);
    chk("rst_wr_issue_valid", wr_issue_valid, 0);
    chk("rst_cpl_valid", cpl_valid, 0);
    chk("rst_rd_outst", rd_outst, 0);
    chk("rst_wr_outst", wr_outst, 0);
    chk("rst_spurious", spurious_cpl, 0);
    chk("rst_issue_tag", issue_tag, 0);
    model_reset();
    @(posedge pclk); #1;
    preset = 0;
  endtask

  // Compare every output with the model at the falling edge, then advance the
  // model to the state the next rising edge produces.
  task automatic step();
    bit exp_pop, credit, g_rd, g_wr, hs;
    logic [TAG_W-1:0] t;
    @(negedge pclk);
    credit  = pending_entry.is_write ? (cnt(1) < MAXWR) : (cnt(0) < MAXRD);
    exp_pop = !m_busy && sched_en && pending_valid && credit;
    if (rd_cpl_valid && wr_cpl_valid) begin g_wr = m_wr_turn; g_rd = !m_wr_turn; end
    else begin g_wr = wr_cpl_valid; g_rd = rd_cpl_valid; end
    chk("pending_pop", pending_pop, exp_pop);
    chk("rd_issue_valid", rd_issue_valid, m_busy && !m_iswr);
    chk("wr_issue_valid", wr_issue_valid, m_busy && m_iswr);
    chk("rd_cpl_ready", rd_cpl_ready, g_rd);
    chk("wr_cpl_ready", wr_cpl_ready, g_wr);
    chk("cpl_valid", cpl_valid, m_cpl_v);
    if (m_cpl_v) begin
      chk("cpl_tag", cpl_tag, m_cpl_t);
      chk("cpl_error", cpl_error, m_cpl_e);
    end
    chk("rd_outst", rd_outst, cnt(0));
    chk("wr_outst", wr_outst, cnt(1));
    chk("spurious_cpl", spurious_cpl, m_spur);
    if (m_busy) begin
      chk("issue_tag", issue_tag, m_tag);
      chk("issue_entry", issue_entry, m_entry);
    end
    m_cpl_v = 0;
    if (g_rd || g_wr) begin
      t = g_wr ? wr_cpl_tag : rd_cpl_tag;
      if (m_infl[t] && m_dirw[t] == g_wr) begin
        m_infl[t] = 0;
        m_cpl_v = 1; m_cpl_t = t; m_cpl_e = g_wr ? wr_cpl_err : rd_cpl_err;
      end else m_spur = 1;
      m_wr_turn = g_rd;
    end
    if (m_busy) begin
      hs = m_iswr ? wr_issue_ready : rd_issue_ready;
      if (hs) m_busy = 0;
    end else if (exp_pop) begin
      m_busy = 1; m_iswr = pending_entry.is_write;
      m_tag = pending_tag; m_entry = pending_entry;
      m_infl[pending_tag] = 1; m_dirw[pending_tag] = pending_entry.is_write;
    end
    @(posedge pclk); #1;
  endtask

  initial begin
    clear_inputs();
    preset = 0;
    model_reset();
    #2;
    do_reset();

    // Single read: pop now, valid next cycle with one read outstanding
    sched_en = 1; rd_issue_ready = 1; wr_issue_ready = 1;
    set_head(1, 0, 0);
    #1 chk("r18_pop", pending_pop, 1);
    step();
    pending_valid = 0;
    #1 chk("r18_rvalid", rd_issue_valid, 1);
    chk("r18_rd_outst", rd_outst, 1);
    step();

    // Read credit limit of two: third read blocks until a completion returns
    do_reset();
    sched_en = 1; rd_issue_ready = 1; wr_issue_ready = 1;
    set_head(1, 0, 0); step();
    set_head(1, 0, 1); step();
    step();
    set_head(1, 0, 2); step();
    rd_cpl_valid = 1; rd_cpl_tag = 0;
    #1 chk("r19_blocked", pending_pop, 0);
    chk("r19_rd_outst", rd_outst, 2);
    step();
    rd_cpl_valid = 0;
    #1 chk("r19_unblocked", pending_pop, 1);
    step();
    pending_valid = 0; step();

    // Simultaneous completions: write wins first after reset
    do_reset();
    sched_en = 1; rd_issue_ready = 1; wr_issue_ready = 1;
    set_head(1, 0, 1); step();
    set_head(1, 1, 2); step();
    step();
    pending_valid = 0; step();
    rd_cpl_valid = 1; rd_cpl_tag = 1; wr_cpl_valid = 1; wr_cpl_tag = 2;
    #1 chk("r20_wr_first", wr_cpl_ready, 1);
    chk("r20_rd_wait", rd_cpl_ready, 0);
    step();
    wr_cpl_valid = 0;
    #1 chk("r20_tag2", cpl_tag, 2);
    step();
    rd_cpl_valid = 0;
    #1 chk("r20_tag1", cpl_tag, 1);
    step();

    // Completion for a tag not in flight is swallowed and flagged
    wr_cpl_valid = 1; wr_cpl_tag = 3;
    #1 chk("r21_ready", wr_cpl_ready, 1);
    step();
    wr_cpl_valid = 0;
    #1 chk("r21_no_cpl", cpl_valid, 0);
    chk("r21_spurious", spurious_cpl, 1);
    chk("r21_wr_outst", wr_outst, 0);
    step();

    // Write credit full: a same-cycle completion does not lend its credit to the pop
    do_reset();
    sched_en = 1; rd_issue_ready = 1; wr_issue_ready = 1;
    for (int i = 0; i < 4; i++) begin set_head(1, 1, i); step(); step(); end
    set_head(1, 1, 4); wr_cpl_valid = 1; wr_cpl_tag = 0;
    #1 chk("r22_blocked", pending_pop, 0);
    chk("r22_full", wr_outst, 4);
    step();
    wr_cpl_valid = 0;
    #1 chk("r22_pop", pending_pop, 1);
    step();
    pending_valid = 0;
    #1 chk("r22_refill", wr_outst, 4);
    step();

    // Reset while a write waits for ready; disabling issue must not drop it first
    do_reset();
    sched_en = 1; wr_issue_ready = 0;
    set_head(1, 1, 5); step();
    pending_valid = 0; sched_en = 0;
    step();
    #1 chk("r13_hold", wr_issue_valid, 1);
    do_reset();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      if (c % 1000 == 999) do_reset();
      sched_en = ($urandom_range(0, 99) < 85);
      pending_valid = 0;
      if ($urandom_range(0, 99) < 70)
        for (int k = 0; k < 8; k++) begin
          int unsigned t = $urandom_range(0, TAG_NUM - 1);
          if (!m_infl[t]) begin set_head(1, 1'($urandom_range(0, 1)), t); break; end
        end
      rd_issue_ready = ($urandom_range(0, 99) < 60);
      wr_issue_ready = ($urandom_range(0, 99) < 60);
      rd_cpl_valid = ($urandom_range(0, 99) < 35);
      rd_cpl_tag   = pick_tag(0);
      rd_cpl_err   = ($urandom_range(0, 99) < 20);
      wr_cpl_valid = ($urandom_range(0, 99) < 35);
      wr_cpl_tag   = pick_tag(1);
      wr_cpl_err   = ($urandom_range(0, 99) < 20);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
